// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
// Latency: n/a (types, constants and a header-packing helper only).
// Backpressure: n/a.
package router_pkg;

  // Transmitter sequencing: command, buffer fill, then the header/payload/parity burst.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_PARITY  = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  // Destination port 3 does not exist on the router.
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Header byte layout: length in the upper six bits, destination in the lower two.
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;

  localparam int MAX_PLD_LEN = 63;
  localparam int CNT_W       = $clog2(MAX_PLD_LEN + 1);
  localparam int BUF_DEPTH   = 64;
  localparam int BUF_AW      = $clog2(BUF_DEPTH);

  typedef struct packed {
    logic [HDR_LEN_MSB-HDR_LEN_LSB:0]   len;
    logic [HDR_ADDR_MSB-HDR_ADDR_LSB:0] addr;
  } hdr_t;

  function automatic hdr_t make_hdr(input logic [CNT_W-1:0] len, input logic [1:0] addr);
    hdr_t h;
    h.len  = len;
    h.addr = addr;
    return h;
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Store-and-forward payload buffer: 64 entries, synchronous write, combinational read.
// Latency: a written byte is readable the cycle after the write; the read is combinational.
// Backpressure: none; the caller never writes more than one packet before draining it.
module router_tx_buf
  import router_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [BUF_AW-1:0] wptr;
  logic [BUF_AW-1:0] rptr;

  // Pointers restart at entry 0 for every new packet.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wptr] <= wr_dat;
  end

  assign rd_dat = mem[rptr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet source: buffers a whole payload, then sends header, payload, parity as one burst.
// Latency: header appears the cycle after the last payload beat; then one byte per non-busy cycle.
// Backpressure: busy=1 holds data_out/pkt_valid; optional ROUTER_TX_ERR_INJ_EN adds inj_err (inverted parity).
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int DATA_W     = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        dest_addr,
  input  logic [5:0]        pld_len,
  output logic              start_ready,
  output logic              cmd_err,
  input  logic [DATA_W-1:0] pld_data,
  input  logic              pld_valid,
  output logic              pld_ready,
  input  logic              busy,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              tx_done
`ifdef ROUTER_TX_ERR_INJ_EN
  ,
  input  logic              inj_err
`endif
);

  localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  len_q;
  logic [1:0]        dest_q;
  logic [DATA_W-1:0] parity;
  logic [DATA_W-1:0] parity_out;
  logic [DATA_W-1:0] rd_dat;
  logic [7:0]        gap_cnt;
  logic              consume;
  logic              cmd_ok;
  logic              load_last;
  logic              pay_last;
  logic              buf_clr;
  logic              wr_en;
  logic              rd_en;

  assign consume   = !busy && (state == ST_HEADER || state == ST_PAYLOAD || state == ST_PARITY);
  assign cmd_ok    = (dest_addr != ADDR_INVALID) && (pld_len != '0);
  assign load_last = pld_valid && ((cnt + CNT_W'(1)) == len_q);
  assign pay_last  = (cnt + CNT_W'(1)) == len_q;
  assign buf_clr   = (state == ST_IDLE) && start && cmd_ok;
  assign wr_en     = (state == ST_LOAD) && pld_valid;
  assign rd_en     = consume && (state == ST_HEADER || state == ST_PAYLOAD);

`ifdef ROUTER_TX_ERR_INJ_EN
  logic inj_q;

  // Capture the corruption request alongside an accepted command.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) inj_q <= 1'b0;
    else if (buf_clr) inj_q <= inj_err;
  end

  assign parity_out = inj_q ? ~parity : parity;
`else
  assign parity_out = parity;
`endif

  router_tx_buf #(.DATA_W(DATA_W)) u_buf (
    .clock  (clock),
    .resetn (resetn),
    .clr    (buf_clr),
    .wr_en  (wr_en),
    .wr_dat (pld_data),
    .rd_en  (rd_en),
    .rd_dat (rd_dat)
  );

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode; transmit states only advance on a consumed byte.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (buf_clr) state_nxt = ST_LOAD;
      ST_LOAD:    if (load_last) state_nxt = ST_HEADER;
      ST_HEADER:  if (consume) state_nxt = ST_PAYLOAD;
      ST_PAYLOAD: if (consume && pay_last) state_nxt = ST_PARITY;
      ST_PARITY:  if (consume) state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:     if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    start_ready = (state == ST_IDLE);
    pld_ready   = (state == ST_LOAD);
  end

  // Datapath: counters, parity and the registered byte presented to the router.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      len_q     <= '0;
      dest_q    <= '0;
      parity    <= '0;
      data_out  <= '0;
      pkt_valid <= 1'b0;
      tx_done   <= 1'b0;
      cmd_err   <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      tx_done <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cmd_ok) begin
              len_q  <= pld_len;
              dest_q <= dest_addr;
              parity <= '0;
              cnt    <= '0;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (pld_valid) begin
            parity <= parity ^ pld_data;
            cnt    <= cnt + 1'b1;
            if (load_last) begin
              data_out  <= make_hdr(len_q, dest_q);
              pkt_valid <= 1'b1;
            end
          end
        end
        ST_HEADER: begin
          if (consume) begin
            parity   <= parity ^ data_out;
            data_out <= rd_dat;
            cnt      <= '0;
          end
        end
        ST_PAYLOAD: begin
          if (consume) begin
            cnt <= cnt + 1'b1;
            if (pay_last) begin
              data_out  <= parity_out;
              pkt_valid <= 1'b0;
            end else begin
              data_out <= rd_dat;
            end
          end
        end
        ST_PARITY: begin
          if (consume) begin
            tx_done <= 1'b1;
            gap_cnt <= '0;
          end
        end
        ST_GAP: gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: queue-based packet model plus literal packet checks.
// Latency: model expects the header the cycle after the last beat and a 2-cycle gap after parity.
// Backpressure: busy is driven directed or random; the model only advances on non-busy cycles.
module tb_router_pkt_tx;

  localparam int GAP = 2;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       start = 1'b0;
  logic [1:0] dest_addr = '0;
  logic [5:0] pld_len = '0;
  logic       start_ready;
  logic       cmd_err;
  logic [7:0] pld_data = '0;
  logic       pld_valid = 1'b0;
  logic       pld_ready;
  logic       busy = 1'b0;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_done;
  logic       inj_err = 1'b0;

  always #5 clock = ~clock;

  router_pkt_tx #(.GAP_CYCLES(GAP), .DATA_W(8)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .dest_addr   (dest_addr),
    .pld_len     (pld_len),
    .start_ready (start_ready),
    .cmd_err     (cmd_err),
    .pld_data    (pld_data),
    .pld_valid   (pld_valid),
    .pld_ready   (pld_ready),
    .busy        (busy),
    .pkt_valid   (pkt_valid),
    .data_out    (data_out),
    .tx_done     (tx_done)
`ifdef ROUTER_TX_ERR_INJ_EN
    ,
    .inj_err     (inj_err)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for command, 1 collecting payload, 2 sending burst, 3 gap
  int         m_phase = 0;
  logic [1:0] m_dest;
  logic [5:0] m_len;
  logic       m_inj;
  logic [7:0] pay_q[$];
  logic [8:0] exp_q[$];
  logic       m_cmd_err = 1'b0;
  logic       m_tx_done = 1'b0;
  int         m_gap = 0;
  int         m_pkts = 0;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_phase   = 0;
      m_cmd_err = 1'b0;
      m_tx_done = 1'b0;
      pay_q.delete();
      exp_q.delete();
    end else begin
      m_cmd_err = 1'b0;
      m_tx_done = 1'b0;
      case (m_phase)
        0: if (start) begin
          if (dest_addr != 2'd3 && pld_len != 6'd0) begin
            m_dest  = dest_addr;
            m_len   = pld_len;
            m_inj   = inj_err;
            pay_q.delete();
            m_phase = 1;
          end else begin
            m_cmd_err = 1'b1;
          end
        end
        1: if (pld_valid) begin
          pay_q.push_back(pld_data);
          if (pay_q.size() == int'(m_len)) begin
            logic [7:0] par;
            par = {m_len, m_dest};
            exp_q.delete();
            exp_q.push_back({1'b1, par});
            foreach (pay_q[i]) begin
              par = par ^ pay_q[i];
              exp_q.push_back({1'b1, pay_q[i]});
            end
            exp_q.push_back({1'b0, m_inj ? ~par : par});
            m_phase = 2;
          end
        end
        2: if (!busy) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            m_tx_done = 1'b1;
            m_pkts++;
            m_gap   = GAP;
            m_phase = (GAP == 0) ? 0 : 3;
          end
        end
        default: begin
          m_gap--;
          if (m_gap == 0) m_phase = 0;
        end
      endcase
    end
  end

  // ---------------- cycle compare ----------------
  bit         chk_en = 1'b0;
  int         hold11 = 0;
  logic [8:0] cap_q[$];

  always @(negedge clock) begin
    if (chk_en && resetn) begin
      chk("start_ready", start_ready, m_phase == 0);
      chk("pld_ready", pld_ready, m_phase == 1);
      chk("cmd_err", cmd_err, m_cmd_err);
      chk("tx_done", tx_done, m_tx_done);
      if (m_phase == 2) begin
        chk("burst_byte", {pkt_valid, data_out}, exp_q[0]);
        if (!busy) cap_q.push_back({pkt_valid, data_out});
        if (pkt_valid && data_out == 8'h11) hold11++;
      end else begin
        chk("pkt_valid_quiet", pkt_valid, 1'b0);
      end
    end
  end

  // ---------------- stimulus ----------------
  int   busy_mode = 0;
  logic busy_force = 1'b0;

  always @(posedge clock) begin
    #2;
    busy = (busy_mode != 0) ? ($urandom % 3 == 0) : busy_force;
  end

  logic [7:0] tx_pay[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!start_ready && k < 500) begin
      tick();
      k++;
    end
    if (!start_ready) timeout_fail("wait_start_ready");
  endtask

  task automatic send_cmd(input logic [1:0] d, input logic [5:0] l, input logic inj);
    wait_ready();
    start     = 1'b1;
    dest_addr = d;
    pld_len   = l;
    inj_err   = inj;
    tick();
    start     = 1'b0;
    dest_addr = 2'($urandom);
    pld_len   = 6'($urandom);
    inj_err   = 1'b0;
  endtask

  task automatic send_payload(input bit rnd);
    int i = 0;
    while (i < tx_pay.size()) begin
      pld_data  = tx_pay[i];
      pld_valid = !rnd || ($urandom % 4 != 0);
      if (rnd && ($urandom % 8 == 0)) start = 1'b1;
      @(posedge clock);
      if (pld_valid) i++;
      #1;
      start = 1'b0;
    end
    // one surplus beat that must be ignored
    pld_valid = rnd ? 1'($urandom % 2) : 1'b0;
    pld_data  = 8'hA5;
    tick();
    pld_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (!(m_pkts >= target && m_phase == 0) && k < 2000) begin
      tick();
      k++;
    end
    if (!(m_pkts >= target && m_phase == 0)) timeout_fail("wait_packet_done");
  endtask

  task automatic run_pkt(input logic [1:0] d, input logic [5:0] l, input logic inj, input bit rnd);
    int t;
    t = m_pkts + 1;
    cap_q.delete();
    send_cmd(d, l, inj);
    send_payload(rnd);
    wait_done(t);
  endtask

  task automatic check_basic(input string tag, input logic [7:0] par);
    logic [8:0] lit[5];
    lit[0] = 9'h10D; lit[1] = 9'h111; lit[2] = 9'h122; lit[3] = 9'h133; lit[4] = {1'b0, par};
    chk({tag, "_len"}, cap_q.size(), 5);
    if (cap_q.size() == 5)
      for (int i = 0; i < 5; i++) chk($sformatf("%s_b%0d", tag, i), cap_q[i], lit[i]);
  endtask

  initial begin
    // reset
    #2 resetn = 1'b0;
    #1;
    chk("rst_pkt_valid", pkt_valid, 1'b0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_tx_done", tx_done, 1'b0);
    chk("rst_cmd_err", cmd_err, 1'b0);
    chk("rst_pld_ready", pld_ready, 1'b0);
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    chk("rel_start_ready", start_ready, 1'b1);
    chk_en = 1'b1;

    // basic packet
    tx_pay = '{8'h11, 8'h22, 8'h33};
    run_pkt(2'd1, 6'd3, 1'b0, 1'b0);
    check_basic("basic", 8'h0D);

    // backpressure on the first payload byte
    cap_q.delete();
    hold11 = 0;
    begin
      int t;
      t = m_pkts + 1;
      send_cmd(2'd1, 6'd3, 1'b0);
      send_payload(1'b0);
      busy_force = 1'b1;
      repeat (3) tick();
      busy_force = 1'b0;
      wait_done(t);
    end
    chk("bp_hold_cycles", hold11, 4);
    check_basic("bp", 8'h0D);

    // invalid commands
    send_cmd(2'd3, 6'd5, 1'b0);
    chk("inv_addr_cmd_err", cmd_err, 1'b1);
    chk("inv_addr_idle", start_ready, 1'b1);
    chk("inv_addr_pld_ready", pld_ready, 1'b0);
    tick();
    chk("inv_addr_pulse_end", cmd_err, 1'b0);
    send_cmd(2'd0, 6'd0, 1'b0);
    chk("inv_len_cmd_err", cmd_err, 1'b1);
    chk("inv_len_idle", start_ready, 1'b1);
    chk("inv_len_pld_ready", pld_ready, 1'b0);
    tick();

    // maximum length
    tx_pay.delete();
    for (int i = 0; i < 63; i++) tx_pay.push_back(8'(i));
    run_pkt(2'd2, 6'd63, 1'b0, 1'b0);
    chk("max_len", cap_q.size(), 65);
    if (cap_q.size() == 65) begin
      chk("max_hdr", cap_q[0], 9'h1FE);
      for (int i = 0; i < 63; i++) chk($sformatf("max_b%0d", i), cap_q[i+1], {1'b1, 8'(i)});
      chk("max_parity", cap_q[64], 9'h0C1);
    end

    // reset in the middle of the payload
    tx_pay.delete();
    for (int i = 0; i < 10; i++) tx_pay.push_back(8'($urandom));
    cap_q.delete();
    send_cmd(2'd0, 6'd10, 1'b0);
    send_payload(1'b0);
    begin
      int k = 0;
      while (cap_q.size() < 6 && k < 100) begin
        tick();
        k++;
      end
      if (cap_q.size() < 6) timeout_fail("mid_reset_wait");
    end
    #2 resetn = 1'b0;
    #1;
    chk("midrst_pkt_valid", pkt_valid, 1'b0);
    chk("midrst_data_out", data_out, 8'h00);
    chk("midrst_pld_ready", pld_ready, 1'b0);
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    tx_pay = '{8'h11, 8'h22, 8'h33};
    run_pkt(2'd1, 6'd3, 1'b0, 1'b0);
    check_basic("after_rst", 8'h0D);

`ifdef ROUTER_TX_ERR_INJ_EN
    run_pkt(2'd1, 6'd3, 1'b1, 1'b0);
    check_basic("inj_on", 8'hF2);
    run_pkt(2'd1, 6'd3, 1'b0, 1'b0);
    check_basic("inj_off", 8'h0D);
`endif

    // randomized traffic with random busy
    busy_mode = 1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom % 6 == 0) begin
        if ($urandom % 2 == 0) send_cmd(2'd3, 6'(1 + $urandom % 63), 1'b0);
        else                   send_cmd(2'($urandom % 3), 6'd0, 1'b0);
        tick();
      end else begin
        logic [5:0] l;
        logic       inj;
        case ($urandom % 4)
          0:       l = 6'd1;
          1:       l = 6'd63;
          default: l = 6'(1 + $urandom % 63);
        endcase
`ifdef ROUTER_TX_ERR_INJ_EN
        inj = 1'($urandom % 2);
`else
        inj = 1'b0;
`endif
        tx_pay.delete();
        for (int i = 0; i < int'(l); i++) tx_pay.push_back(8'($urandom));
        run_pkt(2'($urandom % 3), l, inj, 1'b1);
        chk("rnd_burst_len", cap_q.size(), int'(l) + 2);
      end
    end
    busy_mode = 0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
